// File: rtl/x_ramb_asym_dp.sv
// x_ramb_asym_dp: single-clock true dual-port RAM, ports of unequal width.
// Define X_RAMB_COLL_X_EN to make cross-port overlapping bits read/write x.
module x_ramb_asym_dp #(
  parameter int MEM_BITS = 4096,
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 16,
  parameter int ADDR_A_W = 10,
  parameter int ADDR_B_W = 8,
  parameter int WRITE_MODE_A = 0,
  parameter int WRITE_MODE_B = 0,
  parameter int OUT_REG = 0,
  parameter logic [MEM_BITS-1:0] INIT = '0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ENA,
  input  logic                WEA,
  input  logic [ADDR_A_W-1:0] ADDRA,
  input  logic [WIDTH_A-1:0]  DIA,
  output logic [WIDTH_A-1:0]  DOA,
  output logic                DVA,
  input  logic                ENB,
  input  logic                WEB,
  input  logic [ADDR_B_W-1:0] ADDRB,
  input  logic [WIDTH_B-1:0]  DIB,
  output logic [WIDTH_B-1:0]  DOB,
  output logic                DVB,
  output logic                COLL
);
  localparam int BIT_W = $clog2(MEM_BITS);
  localparam int LOG_WA = $clog2(WIDTH_A);
  localparam int LOG_WB = $clog2(WIDTH_B);

  if (ADDR_A_W != $clog2(MEM_BITS / WIDTH_A) ||
      ADDR_B_W != $clog2(MEM_BITS / WIDTH_B)) begin : g_cfg_err
    $fatal(1, "x_ramb_asym_dp: ADDR_*_W mismatch");
  end

  logic [MEM_BITS-1:0] mem_q = INIT;
  logic [MEM_BITS-1:0] mem_d;
  logic [BIT_W-1:0]    a_lo, b_lo;
  logic [MEM_BITS-1:0] a_mask, b_mask, ovl_mask;
  logic                overlap, a_wr, b_wr;
  logic [WIDTH_A-1:0]  rd_a, a_old;
  logic [WIDTH_B-1:0]  rd_b, b_old;

  logic [WIDTH_A-1:0]  doa1_q, doa1_d;
  logic [WIDTH_B-1:0]  dob1_q, dob1_d;
  logic                dva1_q, dva1_d;
  logic                dvb1_q, dvb1_d;
  logic                coll_q, coll_d;

  assign a_lo = BIT_W'(ADDRA) << LOG_WA;
  assign b_lo = BIT_W'(ADDRB) << LOG_WB;
  assign a_mask = MEM_BITS'({WIDTH_A{1'b1}}) << a_lo;
  assign b_mask = MEM_BITS'({WIDTH_B{1'b1}}) << b_lo;
  assign ovl_mask = a_mask & b_mask;
  assign overlap = |ovl_mask;
  assign a_wr = ENA && WEA;
  assign b_wr = ENB && WEB;
  assign rd_a = mem_q[a_lo +: WIDTH_A];
  assign rd_b = mem_q[b_lo +: WIDTH_B];

`ifdef X_RAMB_COLL_X_EN
  logic [WIDTH_A-1:0] a_xm;
  logic [WIDTH_B-1:0] b_xm;
  assign a_xm = WIDTH_A'(ovl_mask >> a_lo);
  assign b_xm = WIDTH_B'(ovl_mask >> b_lo);
  assign a_old = (ENA && !WEA && b_wr) ?
    ((rd_a & ~a_xm) | ({WIDTH_A{1'bx}} & a_xm)) : rd_a;
  assign b_old = (ENB && !WEB && a_wr) ?
    ((rd_b & ~b_xm) | ({WIDTH_B{1'bx}} & b_xm)) : rd_b;
`else
  assign a_old = rd_a;
  assign b_old = rd_b;
`endif

  // B is written last so it owns any bits both ports write
  always_comb begin
    mem_d = mem_q;
    if (a_wr) mem_d[a_lo +: WIDTH_A] = DIA;
    if (b_wr) mem_d[b_lo +: WIDTH_B] = DIB;
`ifdef X_RAMB_COLL_X_EN
    if (a_wr && b_wr)
      mem_d = (mem_d & ~ovl_mask) |
              ({MEM_BITS{1'bx}} & ovl_mask);
`endif
  end

  always_comb begin
    doa1_d = doa1_q;
    dva1_d = 1'b0;
    if (RST) begin
      doa1_d = '0;
    end else if (ENA) begin
      if (!WEA) begin
        doa1_d = a_old;
        dva1_d = 1'b1;
      end else if (WRITE_MODE_A == 0) begin
        doa1_d = DIA;
        dva1_d = 1'b1;
      end else if (WRITE_MODE_A == 1) begin
        doa1_d = rd_a;
        dva1_d = 1'b1;
      end
    end
  end

  always_comb begin
    dob1_d = dob1_q;
    dvb1_d = 1'b0;
    if (RST) begin
      dob1_d = '0;
    end else if (ENB) begin
      if (!WEB) begin
        dob1_d = b_old;
        dvb1_d = 1'b1;
      end else if (WRITE_MODE_B == 0) begin
        dob1_d = DIB;
        dvb1_d = 1'b1;
      end else if (WRITE_MODE_B == 1) begin
        dob1_d = rd_b;
        dvb1_d = 1'b1;
      end
    end
  end

  always_comb begin
    coll_d = !RST && ENA && ENB && overlap && (WEA || WEB);
  end

  always_ff @(posedge CLK) begin
    mem_q  <= mem_d;
    doa1_q <= doa1_d;
    dva1_q <= dva1_d;
    dob1_q <= dob1_d;
    dvb1_q <= dvb1_d;
    coll_q <= coll_d;
  end

  assign COLL = coll_q;

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH_A-1:0] doa2_q, doa2_d;
    logic [WIDTH_B-1:0] dob2_q, dob2_d;
    logic               dva2_q, dva2_d;
    logic               dvb2_q, dvb2_d;

    always_comb begin
      doa2_d = RST ? '0 : doa1_q;
      dva2_d = RST ? 1'b0 : dva1_q;
      dob2_d = RST ? '0 : dob1_q;
      dvb2_d = RST ? 1'b0 : dvb1_q;
    end

    always_ff @(posedge CLK) begin
      doa2_q <= doa2_d;
      dva2_q <= dva2_d;
      dob2_q <= dob2_d;
      dvb2_q <= dvb2_d;
    end

    assign DOA = doa2_q;
    assign DVA = dva2_q;
    assign DOB = dob2_q;
    assign DVB = dvb2_q;
  end else begin : g_noreg
    assign DOA = doa1_q;
    assign DVA = dva1_q;
    assign DOB = dob1_q;
    assign DVB = dvb1_q;
  end

endmodule

// File: tb/tb_x_ramb_asym_dp.sv
// tb_x_ramb_asym_dp: vector table, hand sequences and random traffic
// on three configurations of x_ramb_asym_dp against a behavioural model.
module tb_x_ramb_asym_dp;
  localparam logic [4095:0] INIT_V = 4096'hBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ena, wea, enb, web;
  logic [9:0]  addra;
  logic [3:0]  dia;
  logic [7:0]  addrb;
  logic [15:0] dib;

  logic [3:0]  doa [3];
  logic [15:0] dob [3];
  logic        dva [3];
  logic        dvb [3];
  logic        coll [3];

  x_ramb_asym_dp #(.INIT(INIT_V)) u0 (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia),
    .DOA(doa[0]), .DVA(dva[0]),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib),
    .DOB(dob[0]), .DVB(dvb[0]), .COLL(coll[0])
  );

  x_ramb_asym_dp #(
    .WRITE_MODE_A(1), .WRITE_MODE_B(1),
    .OUT_REG(1), .INIT(INIT_V)
  ) u1 (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia),
    .DOA(doa[1]), .DVA(dva[1]),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib),
    .DOB(dob[1]), .DVB(dvb[1]), .COLL(coll[1])
  );

  x_ramb_asym_dp #(
    .WRITE_MODE_A(2), .WRITE_MODE_B(2), .INIT(INIT_V)
  ) u2 (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia),
    .DOA(doa[2]), .DVA(dva[2]),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib),
    .DOB(dob[2]), .DVB(dvb[2]), .COLL(coll[2])
  );

  int checks = 0;
  int failures = 0;

  int ma [3] = '{0, 1, 2};
  int mb [3] = '{0, 1, 2};
  int oreg [3] = '{0, 1, 0};

  logic [4095:0] mm [3];
  logic [3:0]  s1a [3], s2a [3];
  logic [15:0] s1b [3], s2b [3];
  logic        s1va [3], s2va [3];
  logic        s1vb [3], s2vb [3];
  logic        ecoll [3];

  typedef struct {
    logic        ena;
    logic        wea;
    logic [9:0]  addra;
    logic [3:0]  dia;
    logic        enb;
    logic        web;
    logic [7:0]  addrb;
    logic [15:0] dib;
    logic [3:0]  exp_doa;
    logic        exp_dva;
    logic [15:0] exp_dob;
    logic        exp_dvb;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Array is a flat bit vector; ports are windows of 4 or 16 bits into it.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      logic [4095:0] old;
      int alo;
      int blo;
      logic ovl;
      old = mm[k];
      alo = int'(addra) * 4;
      blo = int'(addrb) * 16;
      ovl = (alo < blo + 16) && (blo < alo + 4);
      if (ena && wea) mm[k][alo +: 4] = dia;
      if (enb && web) mm[k][blo +: 16] = dib;
      s2a[k]  = rst ? 4'h0 : s1a[k];
      s2va[k] = rst ? 1'b0 : s1va[k];
      s2b[k]  = rst ? 16'h0 : s1b[k];
      s2vb[k] = rst ? 1'b0 : s1vb[k];
      s1va[k] = 1'b0;
      s1vb[k] = 1'b0;
      if (rst) begin
        s1a[k] = 4'h0;
        s1b[k] = 16'h0;
      end else begin
        if (ena) begin
          if (!wea || ma[k] == 1) begin
            s1a[k] = old[alo +: 4];
            s1va[k] = 1'b1;
          end else if (ma[k] == 0) begin
            s1a[k] = dia;
            s1va[k] = 1'b1;
          end
        end
        if (enb) begin
          if (!web || mb[k] == 1) begin
            s1b[k] = old[blo +: 16];
            s1vb[k] = 1'b1;
          end else if (mb[k] == 0) begin
            s1b[k] = dib;
            s1vb[k] = 1'b1;
          end
        end
      end
      ecoll[k] = !rst && ena && enb && ovl && (wea || web);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.doa", k), 32'(doa[k]),
          32'(oreg[k] != 0 ? s2a[k] : s1a[k]));
      chk($sformatf("u%0d.dva", k), 32'(dva[k]),
          32'(oreg[k] != 0 ? s2va[k] : s1va[k]));
      chk($sformatf("u%0d.dob", k), 32'(dob[k]),
          32'(oreg[k] != 0 ? s2b[k] : s1b[k]));
      chk($sformatf("u%0d.dvb", k), 32'(dvb[k]),
          32'(oreg[k] != 0 ? s2vb[k] : s1vb[k]));
      chk($sformatf("u%0d.coll", k), 32'(coll[k]),
          32'(ecoll[k]));
    end
  endtask

  task automatic idle();
    ena = 1'b0; wea = 1'b0;
    enb = 1'b0; web = 1'b0;
    rst = 1'b0;
  endtask

  task automatic opa(input logic we, input int a, input int d);
    ena = 1'b1; wea = we;
    addra = 10'(a); dia = 4'(d);
  endtask

  task automatic opb(input logic we, input int a, input int d);
    enb = 1'b1; web = we;
    addrb = 8'(a); dib = 16'(d);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 10'd4, 4'h1, 1'b0, 1'b0, 8'd0, 16'h0,
               4'h1, 1'b1, 16'hBEEF, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 10'd5, 4'h2, 1'b0, 1'b0, 8'd0, 16'h0,
               4'h2, 1'b1, 16'hBEEF, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 10'd6, 4'h3, 1'b0, 1'b0, 8'd0, 16'h0,
               4'h3, 1'b1, 16'hBEEF, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 10'd7, 4'h4, 1'b0, 1'b0, 8'd0, 16'h0,
               4'h4, 1'b1, 16'hBEEF, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 10'd0, 4'h0, 1'b1, 1'b0, 8'd1, 16'h0,
               4'h4, 1'b0, 16'h4321, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 10'd0, 4'h0, 1'b1, 1'b1, 8'd2, 16'hA5C3,
               4'h4, 1'b0, 16'hA5C3, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 10'd9, 4'h0, 1'b0, 1'b0, 8'd0, 16'h0,
               4'hC, 1'b1, 16'hA5C3, 1'b0};

    for (int k = 0; k < 3; k++) begin
      mm[k] = INIT_V;
      s1a[k] = '0; s2a[k] = '0; s1va[k] = 0; s2va[k] = 0;
      s1b[k] = '0; s2b[k] = '0; s1vb[k] = 0; s2vb[k] = 0;
      ecoll[k] = 0;
    end
    addra = '0; dia = '0; addrb = '0; dib = '0;
    idle();

    // reset with a read pending on B
    rst = 1'b1;
    opb(1'b0, 0, 0);
    tick();
    tick();
    chk("rst_dob", 32'(dob[0]), 32'h0);
    chk("rst_dvb", 32'(dvb[0]), 32'h0);
    chk("rst_dob_oreg", 32'(dob[1]), 32'h0);
    rst = 1'b0;
    tick();
    chk("init_dob", 32'(dob[0]), 32'hBEEF);
    chk("init_dvb", 32'(dvb[0]), 32'h1);
    chk("init_dvb_oreg_early", 32'(dvb[1]), 32'h0);
    idle();
    tick();
    chk("init_dob_oreg", 32'(dob[1]), 32'hBEEF);
    chk("init_dvb_oreg", 32'(dvb[1]), 32'h1);

    // width aliasing vectors on the default instance
    for (int i = 0; i < 7; i++) begin
      idle();
      ena = tbl[i].ena; wea = tbl[i].wea;
      addra = tbl[i].addra; dia = tbl[i].dia;
      enb = tbl[i].enb; web = tbl[i].web;
      addrb = tbl[i].addrb; dib = tbl[i].dib;
      tick();
      chk($sformatf("vec%0d.doa", i), 32'(doa[0]),
          32'(tbl[i].exp_doa));
      chk($sformatf("vec%0d.dva", i), 32'(dva[0]),
          32'(tbl[i].exp_dva));
      chk($sformatf("vec%0d.dob", i), 32'(dob[0]),
          32'(tbl[i].exp_dob));
      chk($sformatf("vec%0d.dvb", i), 32'(dvb[0]),
          32'(tbl[i].exp_dvb));
    end

    // write modes on A addr 0 (old contents F from INIT)
    idle(); opa(1'b1, 0, 3); tick();
    idle(); opa(1'b1, 0, 9); tick();
    chk("wm0_doa", 32'(doa[0]), 32'h9);
    chk("wm2_doa_hold", 32'(doa[2]), 32'hC);
    chk("wm2_dva", 32'(dva[2]), 32'h0);
    chk("wm1_doa_first", 32'(doa[1]), 32'hF);
    idle(); tick();
    chk("wm1_doa", 32'(doa[1]), 32'h3);
    chk("wm1_dva", 32'(dva[1]), 32'h1);

    // write/write collision
    idle(); opa(1'b1, 4, 4'hF); opb(1'b1, 1, 16'h0000); tick();
    chk("ww_coll", 32'(coll[0]), 32'h1);
    chk("ww_coll_oreg", 32'(coll[1]), 32'h1);
    idle(); opb(1'b0, 1, 0); tick();
    chk("ww_coll_pulse", 32'(coll[0]), 32'h0);
    chk("ww_dob", 32'(dob[0]), 32'h0000);

    // read/write collision
    idle(); opb(1'b1, 1, 16'h1234); tick();
    idle(); opb(1'b0, 1, 0); opa(1'b1, 5, 4'h7); tick();
    chk("rw_dob_old", 32'(dob[0]), 32'h1234);
    chk("rw_coll", 32'(coll[0]), 32'h1);
    idle(); opb(1'b0, 1, 0); tick();
    chk("rw_dob_new", 32'(dob[0]), 32'h1274);

    // reset mid-stream with the output register
    idle(); opb(1'b0, 1, 0); tick();
    rst = 1'b1; tick();
    chk("mid_rst_dob", 32'(dob[1]), 32'h0);
    chk("mid_rst_dvb", 32'(dvb[1]), 32'h0);
    rst = 1'b0; tick();
    chk("mid_slot_dob", 32'(dob[1]), 32'h0);
    chk("mid_slot_dvb", 32'(dvb[1]), 32'h0);
    idle(); tick();
    chk("mid_resume_dob", 32'(dob[1]), 32'h1274);
    chk("mid_resume_dvb", 32'(dvb[1]), 32'h1);

    // random traffic concentrated on a small aliasing window
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 31) == 0);
      ena = ($urandom_range(0, 3) != 0);
      wea = 1'($urandom_range(0, 1));
      addra = 10'($urandom_range(0, 31));
      dia = 4'($urandom);
      enb = ($urandom_range(0, 3) != 0);
      web = 1'($urandom_range(0, 1));
      addrb = 8'($urandom_range(0, 7));
      dib = 16'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/x_ramb_asym_dp.md
Name: x_ramb_asym_dp

Overview:
- Parametrised, single-clock, true dual-port block RAM with independently sized port widths over one shared bit array.
- Successor to the fixed 4/16-bit dual-port primitives. Adds per-port write modes, a deterministic cross-port collision policy, an optional output pipeline stage and read-valid strobes.
- Used as the generic memory cell for FIFOs and width converters in simulation netlists.

Parameters:
- MEM_BITS, 4096, total array size in bits; power of two.
- WIDTH_A, 4, port A data width; power of two, divides MEM_BITS.
- WIDTH_B, 16, port B data width; power of two, divides MEM_BITS.
- ADDR_A_W, 10, port A address width; must equal log2(MEM_BITS/WIDTH_A).
- ADDR_B_W, 8, port B address width; must equal log2(MEM_BITS/WIDTH_B).
- WRITE_MODE_A, 0, port A output during a write: 0 write-first, 1 read-first, 2 no-change.
- WRITE_MODE_B, 0, port B output during a write; same encoding as WRITE_MODE_A.
- OUT_REG, 0, 1 adds one output pipeline register on both ports.
- INIT, {MEM_BITS{1'b0}}, initial array contents; bit n maps to mem[n].

Ports:
- CLK  input  1  sole clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset of output and pipeline state; array contents are untouched.
- ENA  input  1  port A enable.
- WEA  input  1  port A write enable; qualified by ENA.
- ADDRA  input  ADDR_A_W  port A word address.
- DIA  input  WIDTH_A  port A write data.
- DOA  output  WIDTH_A  port A read data.
- DVA  output  1  port A read-data-valid strobe.
- ENB  input  1  port B enable.
- WEB  input  1  port B write enable; qualified by ENB.
- ADDRB  input  ADDR_B_W  port B word address.
- DIB  input  WIDTH_B  port B write data.
- DOB  output  WIDTH_B  port B read data.
- DVB  output  1  port B read-data-valid strobe.
- COLL  output  1  cross-port collision pulse.

Behaviour:
- Mapping: port A word i occupies mem[i*WIDTH_A +: WIDTH_A]; port B likewise. With defaults, A addresses 4..7 alias B address 1, nibble 0 being the LSB.
- Reset: on RST, DOA, DOB, DVA, DVB, COLL and the pipeline registers clear to 0 on the next edge. RST overrides EN. Any access issued in a reset cycle has no output effect; its memory write still occurs.
- Read (EN=1, WE=0): stage-1 output gets the array data as it was before this edge.
- Write (EN=1, WE=1): the array is updated at the edge. Stage-1 output depends on the write mode:
  - mode 0: stage-1 output gets DI.
  - mode 1: stage-1 output gets the old contents.
  - mode 2: stage-1 output holds its previous value.
- DV, stage 1: asserts one cycle after any enabled read, or any enabled write in mode 0/1. It is 0 otherwise, including mode-2 writes and EN=0 cycles.
- EN=0: the port's output holds its value.
- Latency: OUT_REG=0 gives DO/DV one cycle after the request. OUT_REG=1 gives two cycles; the stage-2 register loads every cycle, so DV is delayed with its data.
- Cross-port overlap is defined as the two ports' bit ranges intersecting.
  - Write/write overlap: overlapping bits take port B data, non-overlapping bits take each port's own data.
  - Read/write overlap: the reader sees the old data.
  - The writer's output follows its own write mode, using its own DI.
- COLL: pulses high for one cycle, one cycle after any overlap in which at least one port writes. It is not delayed by OUT_REG.
- Same-port back-to-back write then read of the same address: the read returns the new data.
- Elaboration: a mismatch between ADDR_*_W and the derived address width is a fatal $display plus $finish at time 0.

Optional Feature:
- X_RAMB_COLL_X_EN
- Defined: on a write/write overlap the overlapping bits are written 'x' instead of the B-wins policy. On a read/write overlap the reader's overlapping output bits are 'x'. This matches silicon-undefined behaviour for sign-off simulation.
- Undefined: the deterministic policy above applies. COLL behaves identically either way.

Test Plan:
- Reset/INIT: INIT bits 15:0 = 16'hBEEF, RST for 2 cycles, then read B addr 0 -> DOB=16'h0000 and DVB=0 during reset. After reset the read gives DOB=16'hBEEF, DVB=1 one cycle later (two cycles with OUT_REG=1).
- Width aliasing: write A addrs 4,5,6,7 with 1,2,3,4, then read B addr 1 -> DOB=16'h4321. Write B addr 2 = 16'hA5C3, then read A addr 9 -> DOA=4'hC.
- Write modes: mem A addr 0 = 4'h3, write 4'h9 to it -> DOA=9 in mode 0, 3 in mode 1, previous DOA held with DVA=0 in mode 2.
- Collision: same cycle A writes addr 4 = 4'hF and B writes addr 1 = 16'h0000 -> COLL=1 for one cycle. B addr 1 then reads 16'h0000, or 16'hxxx0... is wrong: with X_RAMB_COLL_X_EN, bits 3:0 read 'x' and the remaining bits read 0.
- Read/write overlap: B reads addr 1 (holding 16'h1234) while A writes addr 5 = 4'h7 -> DOB=16'h1234, COLL=1. The following B read returns 16'h1274.
- Reset mid-stream (OUT_REG=1): B reads on consecutive cycles with RST asserted in the second cycle -> DVB and DOB are 0 for that slot. The next read resumes with 2-cycle latency.
